// File: rtl/fpga_clk_cfg_pkg.sv
// Shared types and constants for the clock-generator configuration-port arbiter.
package fpga_clk_cfg_pkg;

  localparam int CFG_ADDR_W = 4;
  localparam int CFG_DATA_W = 32;
  localparam logic [31:0] CFG_ERR_DATA = 32'hDEADDA7A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } cfg_arb_state_e;

  typedef struct packed {
    logic [CFG_ADDR_W-1:0] add;
    logic [CFG_DATA_W-1:0] data;
    logic                  wrn;
  } cfg_txn_t;

endpackage

// File: rtl/fpga_clk_cfg_arbiter_rr_arb_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arb_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int               cand;
    logic [IDX_W-1:0] c;
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      c = IDX_W'(cand);
      if (!valid && req[c]) begin
        valid    = 1'b1;
        grant[c] = 1'b1;
        idx      = c;
      end
    end
  end

endmodule

// File: rtl/fpga_clk_cfg_arbiter.sv
// Round-robin arbiter sharing the fpga_clk_gen config port among N_REQ masters.
// Optional ISSUE timeout abort is enabled by defining FPGA_CLK_CFG_TIMEOUT_EN.
module fpga_clk_cfg_arbiter
  import fpga_clk_cfg_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = CFG_ADDR_W,
  parameter int DATA_W = CFG_DATA_W
`ifdef FPGA_CLK_CFG_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        up_req_i,
  input  logic [N_REQ*ADDR_W-1:0] up_add_i,
  input  logic [N_REQ*DATA_W-1:0] up_data_i,
  input  logic [N_REQ-1:0]        up_wrn_i,
  output logic [N_REQ-1:0]        up_ack_o,
  output logic [DATA_W-1:0]       up_r_data_o,
  output logic                    up_err_o,
  output logic                    cfg_req_o,
  output logic [ADDR_W-1:0]       cfg_add_o,
  output logic [DATA_W-1:0]       cfg_data_o,
  output logic                    cfg_wrn_o,
  input  logic                    cfg_ack_i,
  input  logic [DATA_W-1:0]       cfg_r_data_i,
  output logic                    busy_o
);

  localparam int IDX_W = $clog2(N_REQ);

  cfg_arb_state_e   state_q, state_d;
  logic [IDX_W-1:0] ptr_q, grant_idx_q, pick_idx;
  logic [N_REQ-1:0] grant_oh_q, pick_grant;
  logic             pick_valid;
  cfg_txn_t         txn_q;
  logic             cfg_req_q;
  logic [DATA_W-1:0] r_data_q;

  rr_arb_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (up_req_i),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef FPGA_CLK_CFG_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_q;
  logic             expire;
  logic             err_q;

  // An ack in the expiry cycle takes priority, so expiry only counts without ack.
  assign expire = (state_q == ISSUE) && !cfg_ack_i && (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == IDLE) begin
      tmo_q <= '0;
    end else if (state_q == ISSUE) begin
      if (cfg_ack_i) err_q <= 1'b0;
      else if (expire) err_q <= 1'b1;
      else tmo_q <= tmo_q + 1'b1;
    end
  end

  assign up_err_o = err_q;
`else
  assign up_err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (pick_valid) state_d = ISSUE;
      ISSUE: begin
        if (cfg_ack_i) state_d = RESP;
`ifdef FPGA_CLK_CFG_TIMEOUT_EN
        else if (expire) state_d = RESP;
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_idx_q <= '0;
      grant_oh_q  <= '0;
      txn_q       <= '0;
      cfg_req_q   <= 1'b0;
      r_data_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_idx_q <= pick_idx;
            grant_oh_q  <= pick_grant;
            txn_q.add   <= up_add_i[pick_idx*ADDR_W +: ADDR_W];
            txn_q.data  <= up_data_i[pick_idx*DATA_W +: DATA_W];
            txn_q.wrn   <= up_wrn_i[pick_idx];
            cfg_req_q   <= 1'b1;
          end
        end
        ISSUE: begin
          if (cfg_ack_i) begin
            r_data_q  <= cfg_r_data_i;
            cfg_req_q <= 1'b0;
          end
`ifdef FPGA_CLK_CFG_TIMEOUT_EN
          else if (expire) begin
            r_data_q  <= CFG_ERR_DATA;
            cfg_req_q <= 1'b0;
          end
`endif
        end
        RESP: begin
          ptr_q <= (grant_idx_q == IDX_W'(N_REQ - 1)) ? '0 : IDX_W'(grant_idx_q + 1'b1);
        end
        default: ;
      endcase
    end
  end

  assign up_ack_o    = (state_q == RESP) ? grant_oh_q : '0;
  assign up_r_data_o = r_data_q;
  assign cfg_req_o   = cfg_req_q;
  assign cfg_add_o   = txn_q.add;
  assign cfg_data_o  = txn_q.data;
  assign cfg_wrn_o   = txn_q.wrn;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_fpga_clk_cfg_arbiter.sv
// Directed self-checking bench for fpga_clk_cfg_arbiter (honours FPGA_CLK_CFG_TIMEOUT_EN).
module tb_fpga_clk_cfg_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   up_req = '0;
  logic [15:0]  up_add = '0;
  logic [127:0] up_data = '0;
  logic [3:0]   up_wrn = '0;
  logic [3:0]   up_ack;
  logic [31:0]  up_r_data;
  logic         up_err;
  logic         cfg_req;
  logic [3:0]   cfg_add;
  logic [31:0]  cfg_data;
  logic         cfg_wrn;
  logic         cfg_ack = 1'b0;
  logic [31:0]  cfg_r_data = '0;
  logic         busy;

  int tests = 0;
  int fails = 0;

  // Downstream model controls
  logic        ack_en = 1'b1;
  int          ack_delay = 0;
  int          dly_cnt = 0;
  logic [31:0] ds_rdata = '0;

  // Values captured while waiting for an upstream ack
  logic        cap_seen;
  logic [3:0]  cap_add;
  logic [31:0] cap_data;
  logic        cap_wrn;
  int          req_cycles;
  int          hold_bad;
  logic [31:0] ack_rdata;
  logic        ack_err;

`ifdef FPGA_CLK_CFG_TIMEOUT_EN
  localparam int DLY = 5;
`else
  localparam int DLY = 10;
`endif

  fpga_clk_cfg_arbiter #(
    .N_REQ(4), .ADDR_W(4), .DATA_W(32)
`ifdef FPGA_CLK_CFG_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .up_req_i     (up_req),
    .up_add_i     (up_add),
    .up_data_i    (up_data),
    .up_wrn_i     (up_wrn),
    .up_ack_o     (up_ack),
    .up_r_data_o  (up_r_data),
    .up_err_o     (up_err),
    .cfg_req_o    (cfg_req),
    .cfg_add_o    (cfg_add),
    .cfg_data_o   (cfg_data),
    .cfg_wrn_o    (cfg_wrn),
    .cfg_ack_i    (cfg_ack),
    .cfg_r_data_i (cfg_r_data),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  // Downstream: acks after ack_delay cycles of a visible request, for one cycle.
  always @(negedge clk) begin
    if (rst) begin
      cfg_ack = 1'b0;
      dly_cnt = 0;
    end else if (cfg_req && !cfg_ack && ack_en) begin
      if (dly_cnt >= ack_delay) begin
        cfg_ack    = 1'b1;
        cfg_r_data = ds_rdata;
      end else begin
        dly_cnt++;
      end
    end else begin
      cfg_ack = 1'b0;
      if (!cfg_req) dly_cnt = 0;
    end
  end

  task automatic set_req(input int k, input logic [3:0] a, input logic [31:0] d, input logic w);
    up_add[k*4 +: 4]   = a;
    up_data[k*32 +: 32] = d;
    up_wrn[k]          = w;
    up_req[k]          = 1'b1;
  endtask

  task automatic wait_ack(input int budget, output logic got, output int cyc, output logic [3:0] ack);
    got = 1'b0; cyc = 0; ack = '0;
    cap_seen = 1'b0; req_cycles = 0; hold_bad = 0;
    while (!got && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (cfg_req) begin
        req_cycles++;
        if (!cap_seen) begin
          cap_seen = 1'b1; cap_add = cfg_add; cap_data = cfg_data; cap_wrn = cfg_wrn;
        end else if (cfg_add !== cap_add || cfg_data !== cap_data || cfg_wrn !== cap_wrn) begin
          hold_bad++;
        end
      end
      if (up_ack !== 4'b0000) begin
        got = 1'b1; ack = up_ack; ack_rdata = up_r_data; ack_err = up_err;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    up_req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (up_ack !== 4'b0) begin fails++; $display("FAIL reset_ack got=%b exp=0000", up_ack); end
    tests++; if (cfg_req !== 1'b0) begin fails++; $display("FAIL reset_cfg_req got=%b exp=0", cfg_req); end
    tests++; if (cfg_add !== 4'h0 || cfg_data !== 32'h0 || cfg_wrn !== 1'b0) begin
      fails++; $display("FAIL reset_cfg_fields got=%h/%h/%b exp=0/0/0", cfg_add, cfg_data, cfg_wrn); end
    tests++; if (up_r_data !== 32'h0 || up_err !== 1'b0) begin
      fails++; $display("FAIL reset_resp got=%h/%b exp=0/0", up_r_data, up_err); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single_read();
    logic got; int cyc; logic [3:0] ack;
    ack_delay = 0; ack_en = 1'b1; ds_rdata = 32'h0000_1234;
    set_req(2, 4'h3, 32'h1111_2222, 1'b0);
    wait_ack(20, got, cyc, ack);
    up_req[2] = 1'b0;
    tests++; if (!got || cyc != 2) begin fails++; $display("FAIL single_latency got=%0d exp=2 (ack seen %b)", cyc, got); end
    tests++; if (ack !== 4'b0100) begin fails++; $display("FAIL single_ack got=%b exp=0100", ack); end
    tests++; if (cap_add !== 4'h3 || cap_wrn !== 1'b0) begin
      fails++; $display("FAIL single_cfg got add=%h wrn=%b exp add=3 wrn=0", cap_add, cap_wrn); end
    tests++; if (ack_rdata !== 32'h0000_1234 || ack_err !== 1'b0) begin
      fails++; $display("FAIL single_rdata got=%h err=%b exp=00001234 err=0", ack_rdata, ack_err); end
    @(negedge clk);
    tests++; if (up_ack !== 4'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL single_pulse got ack=%b busy=%b exp 0000/0", up_ack, busy); end
  endtask

  task automatic test_all_four();
    logic got; int cyc; logic [3:0] ack;
    do_reset();
    ds_rdata = 32'h0BAD_F00D;
    for (int k = 0; k < 4; k++) set_req(k, 4'(k * 3 + 1), 32'hC0DE_0000 | 32'(k), k[0]);
    for (int j = 0; j < 4; j++) begin
      wait_ack(20, got, cyc, ack);
      up_req[j] = 1'b0;
      tests++; if (!got || ack !== 4'(1 << j)) begin
        fails++; $display("FAIL all4_order[%0d] got=%b exp=%b", j, ack, 4'(1 << j)); end
      tests++; if (cyc != ((j == 0) ? 2 : 3)) begin
        fails++; $display("FAIL all4_spacing[%0d] got=%0d exp=%0d", j, cyc, (j == 0) ? 2 : 3); end
      tests++; if (cap_add !== 4'(j * 3 + 1) || cap_data !== (32'hC0DE_0000 | 32'(j)) || cap_wrn !== j[0]) begin
        fails++; $display("FAIL all4_fields[%0d] got=%h/%h/%b exp=%h/%h/%b", j, cap_add, cap_data, cap_wrn,
                          4'(j * 3 + 1), 32'hC0DE_0000 | 32'(j), j[0]); end
      tests++; if (ack_rdata !== 32'h0BAD_F00D) begin
        fails++; $display("FAIL all4_rdata[%0d] got=%h exp=0badf00d", j, ack_rdata); end
    end
  endtask

  task automatic test_fairness();
    logic got; int cyc; logic [3:0] ack;
    logic [3:0] order [4];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b1000; order[3] = 4'b0010;
    do_reset();
    set_req(0, 4'h2, 32'h0, 1'b1);
    set_req(1, 4'h5, 32'h1, 1'b1);
    set_req(3, 4'h9, 32'h3, 1'b1);
    for (int j = 0; j < 4; j++) begin
      wait_ack(20, got, cyc, ack);
      if (ack[0]) up_req[0] = 1'b0;
      if (ack[3]) up_req[3] = 1'b0;
      tests++; if (!got || ack !== order[j]) begin
        fails++; $display("FAIL fair_order[%0d] got=%b exp=%b", j, ack, order[j]); end
    end
    up_req = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_delayed_ack();
    logic got; int cyc; logic [3:0] ack;
    ack_delay = DLY; ds_rdata = 32'h0000_00A5;
    set_req(0, 4'h5, 32'h5555_AAAA, 1'b1);
    fork
      wait_ack(50, got, cyc, ack);
      begin
        repeat (3) @(negedge clk);
        up_data[31:0] = 32'hFFFF_0000;
        up_add[3:0]   = 4'hE;
      end
    join
    up_req[0] = 1'b0;
    ack_delay = 0;
    tests++; if (!got || ack !== 4'b0001) begin fails++; $display("FAIL delay_ack got=%b exp=0001", ack); end
    tests++; if (req_cycles != DLY + 1) begin
      fails++; $display("FAIL delay_req_cycles got=%0d exp=%0d", req_cycles, DLY + 1); end
    tests++; if (hold_bad != 0 || cap_add !== 4'h5 || cap_data !== 32'h5555_AAAA || cap_wrn !== 1'b1) begin
      fails++; $display("FAIL delay_hold got bad=%0d %h/%h/%b exp 0 5/5555aaaa/1", hold_bad, cap_add, cap_data, cap_wrn); end
    tests++; if (ack_rdata !== 32'h0000_00A5 || ack_err !== 1'b0) begin
      fails++; $display("FAIL delay_rdata got=%h/%b exp=000000a5/0", ack_rdata, ack_err); end
    @(negedge clk);
  endtask

`ifdef FPGA_CLK_CFG_TIMEOUT_EN
  task automatic test_timeout();
    logic got; int cyc; logic [3:0] ack;
    ack_en = 1'b0;
    set_req(1, 4'h7, 32'h7777_0000, 1'b1);
    wait_ack(40, got, cyc, ack);
    up_req[1] = 1'b0;
    ack_en = 1'b1;
    tests++; if (req_cycles != 8) begin fails++; $display("FAIL tmo_req_cycles got=%0d exp=8", req_cycles); end
    tests++; if (!got || ack !== 4'b0010) begin fails++; $display("FAIL tmo_ack got=%b exp=0010", ack); end
    tests++; if (ack_rdata !== 32'hDEADDA7A || ack_err !== 1'b1) begin
      fails++; $display("FAIL tmo_resp got=%h/%b exp=deadda7a/1", ack_rdata, ack_err); end
    ds_rdata = 32'h0000_0042;
    set_req(2, 4'h1, 32'h0, 1'b0);
    wait_ack(20, got, cyc, ack);
    up_req[2] = 1'b0;
    tests++; if (!got || ack !== 4'b0100 || ack_rdata !== 32'h42 || ack_err !== 1'b0) begin
      fails++; $display("FAIL tmo_next got=%b/%h/%b exp=0100/00000042/0", ack, ack_rdata, ack_err); end
    @(negedge clk);
  endtask
`else
  task automatic test_no_timeout();
    logic got; int cyc; logic [3:0] ack;
    ack_en = 1'b0;
    set_req(1, 4'h7, 32'h7777_0000, 1'b1);
    wait_ack(40, got, cyc, ack);
    tests++; if (got || cfg_req !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL wait_forever got ack=%b req=%b busy=%b exp 0/1/1", got, cfg_req, busy); end
    ds_rdata = 32'h0000_0042;
    ack_en = 1'b1;
    wait_ack(10, got, cyc, ack);
    up_req[1] = 1'b0;
    tests++; if (!got || ack !== 4'b0010 || ack_rdata !== 32'h42 || ack_err !== 1'b0) begin
      fails++; $display("FAIL wait_complete got=%b/%h/%b exp=0010/00000042/0", ack, ack_rdata, ack_err); end
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid_issue();
    logic got; int cyc; logic [3:0] ack;
    // Leave the pointer at 3 first so a restart at 0 is observable.
    do_reset();
    ack_delay = 0;
    set_req(2, 4'h4, 32'h0, 1'b0);
    wait_ack(20, got, cyc, ack);
    up_req[2] = 1'b0;
    @(negedge clk);
    ack_delay = 20;
    set_req(3, 4'hB, 32'hB0B0_B0B0, 1'b1);
    repeat (3) @(negedge clk);
    tests++; if (cfg_req !== 1'b1) begin fails++; $display("FAIL rstmid_issue got=%b exp=1", cfg_req); end
    rst = 1'b1;
    up_req = '0;
    @(negedge clk);
    tests++; if (cfg_req !== 1'b0 || busy !== 1'b0 || up_ack !== 4'b0) begin
      fails++; $display("FAIL rstmid_abort got req=%b busy=%b ack=%b exp 0/0/0000", cfg_req, busy, up_ack); end
    rst = 1'b0;
    ack_delay = 0;
    set_req(1, 4'h6, 32'h0, 1'b0);
    set_req(3, 4'hC, 32'h0, 1'b0);
    wait_ack(20, got, cyc, ack);
    tests++; if (!got || ack !== 4'b0010) begin
      fails++; $display("FAIL rstmid_ptr got=%b exp=0010", ack); end
    up_req = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_all_four();
    test_fairness();
    test_delayed_ack();
`ifdef FPGA_CLK_CFG_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_issue();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpga_clk_cfg_arbiter.md
Name: fpga_clk_cfg_arbiter

Overview:
- Shares the single configuration port of the FPGA clock generator (req/ack, 4-bit address, 32-bit data, write-not-read) among N_REQ requesters, e.g. SoC control, peripheral, cluster and debug masters.
- Round-robin arbitration, one transaction in flight.
- Holds the downstream request stable until it is acknowledged, then returns the ack and read data to the granted requester.
- Sits between the APB/soc_ctrl config masters and fpga_clk_gen.

Parameters:
- N_REQ, 4: number of upstream requesters (≥2).
- ADDR_W, 4: config address width.
- DATA_W, 32: config data width.
- TIMEOUT_CYCLES, 256: ISSUE cycles without ack before abort (timeout feature only; ≥1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- up_req_i  in  N_REQ  per-requester request level.
- up_add_i  in  N_REQ*ADDR_W  packed addresses; requester k at [k*ADDR_W +: ADDR_W].
- up_data_i  in  N_REQ*DATA_W  packed write data.
- up_wrn_i  in  N_REQ  1 = write, 0 = read.
- up_ack_o  out  N_REQ  one-hot, one-cycle ack pulse.
- up_r_data_o  out  DATA_W  read data, valid only with up_ack_o.
- up_err_o  out  1  transaction aborted by timeout, valid with up_ack_o.
- cfg_req_o  out  1  downstream request.
- cfg_add_o  out  ADDR_W  downstream address.
- cfg_data_o  out  DATA_W  downstream write data.
- cfg_wrn_o  out  1  downstream write-not-read.
- cfg_ack_i  in  1  downstream ack.
- cfg_r_data_i  in  DATA_W  downstream read data, sampled with cfg_ack_i.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - FSM = IDLE, RR pointer = 0.
  - All outputs 0; cfg_add_o / cfg_data_o / up_r_data_o = 0.
  - Timeout counter = 0.
- Upstream protocol:
  - Requester raises up_req_i with address/data/wrn stable.
  - Holds them until its up_ack_o pulse.
  - Deasserts up_req_i in the cycle after the ack.
  - Fields are latched at grant; changes afterwards are ignored.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any up_req_i is set, grant the first set bit searching from the RR pointer upward, with wrap.
  - Latch that requester's address/data/wrn into the cfg_* registers, set cfg_req_o = 1, go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE:
  - cfg_req_o and the cfg_* fields are held stable.
  - When cfg_ack_i = 1 (sampled while cfg_req_o = 1): register cfg_r_data_i into up_r_data_o, clear cfg_req_o, go to RESP.
  - A cfg_ack_i arriving while not in ISSUE is ignored.
- RESP:
  - up_ack_o[grant] = 1 for exactly this cycle, with up_r_data_o and up_err_o valid.
  - RR pointer ← (grant + 1) mod N_REQ; go to IDLE.
  - On writes, up_r_data_o carries whatever the downstream returned.
- Latency: with ack-always downstream, the upstream ack appears 2 cycles after up_req_i is sampled in IDLE (IDLE → ISSUE → RESP). Minimum spacing between back-to-back grants is 3 cycles.
- Fairness: a requester waits at most N_REQ−1 other transactions. Simultaneous requests are resolved purely by the RR pointer.
- Request dropped before ack (protocol violation): the transaction still completes downstream and the ack pulse is still emitted.
- Reset asserted mid-ISSUE: cfg_req_o drops the next cycle and no upstream ack is issued.
- busy_o = (state ≠ IDLE).

Optional Feature:
- Macro: FPGA_CLK_CFG_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ISSUE and increments each ISSUE cycle without ack.
  - When it reaches TIMEOUT_CYCLES−1 with no ack: clear cfg_req_o, set up_r_data_o = 32'hDEADDA7A and up_err_o = 1, go to RESP.
  - An ack in the same cycle as expiry wins: normal completion, err = 0.
- Undefined: ISSUE waits indefinitely; up_err_o is tied to 0 and there is no counter.

Decomposition:
- Package fpga_clk_cfg_pkg holds:
  - state enum cfg_arb_state_e {IDLE, ISSUE, RESP};
  - CFG_ERR_DATA = 32'hDEADDA7A;
  - a struct cfg_txn_t {add, data, wrn}.
- One sub-module, rr_arb_pick: combinational first-set-from-pointer search returning a one-hot grant and its index.

Test Plan:
- Single read: downstream acks one cycle after cfg_req_o with r_data 32'h0000_1234; requester 2 reads address 4'h3 → cfg_add_o = 3, cfg_wrn_o = 0; up_ack_o = 4'b0100 exactly 2 cycles after the request is sampled; up_r_data_o = 32'h1234; up_err_o = 0.
- All 4 requesters assert in the same cycle after reset → grant order 0, 1, 2, 3; acks 3 cycles apart; each transaction carries its own address/data on cfg_*.
- Requester 1 requests continuously while requesters 0 and 3 also request → requester 1 is never granted twice before both 0 and 3 have been served.
- Downstream ack delayed 10 cycles → cfg_req_o and fields stay stable for all 10 cycles; a change of up_data_i during the wait is not propagated.
- Timeout (macro defined, TIMEOUT_CYCLES = 8), downstream never acks → cfg_req_o falls after 8 ISSUE cycles; up_ack_o pulses with up_r_data_o = 32'hDEADDA7A and up_err_o = 1; the next requester is then served normally.
- rst_i asserted in the 3rd ISSUE cycle → the next cycle shows cfg_req_o = 0, busy_o = 0, no up_ack_o; after release, the RR pointer restarts at requester 0.
